// File: rtl/tt_pin_cmd_responder_if.sv
// Pin-level bundle between the host pins and the command responder.
// Handshake: host holds ui_in/uio_in stable from req (ui_in[7]) rise until ack (uo_out[7]) is seen, then drops req; ack falls after req is seen low.
interface tt_pin_cmd_responder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [1:0] dbg_state;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe, dbg_state
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe, dbg_state
    );
endinterface

// File: rtl/tt_pin_cmd_responder.sv
// Pin-level command responder: synchronizes req, executes READ/WRITE/ADD/STATUS
// against a small register file and answers with ack, err and optional read data.
module tt_pin_cmd_responder #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tt_pin_cmd_responder_if.slave   pins
);
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic [1:0]             op_c;
    logic [3:0]             addr_c;
    logic [7:0]             data_c;
    logic [7:0]             regs [NREGS];
    logic [7:0]             txn_cnt;
    logic [7:0]             rsp_q;
    logic                   ack_q;
    logic                   err_q;
    logic                   oe_q;

    logic [ADDR_W-1:0]      idx;
    logic                   addr_bad;
    logic [7:0]             cur;
    logic [7:0]             sum;
    logic                   unused_ui4;

    assign req_s      = req_sync[SYNC_STAGES-1];
    assign unused_ui4 = pins.ui_in[4];

    // Address is 4 bits on the pins; anything at or above NREGS is rejected.
    always_comb begin
        idx      = addr_c[ADDR_W-1:0];
        addr_bad = ({1'b0, addr_c} >= 5'(NREGS));
        cur      = regs[idx];
        sum      = cur + data_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_sync <= '0;
            op_c     <= '0;
            addr_c   <= '0;
            data_c   <= '0;
            txn_cnt  <= '0;
            rsp_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            oe_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], pins.ui_in[7]};
            if (!pins.ena) begin
                state <= IDLE;
                ack_q <= 1'b0;
                err_q <= 1'b0;
                oe_q  <= 1'b0;
                rsp_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        ack_q <= 1'b0;
                        err_q <= 1'b0;
                        oe_q  <= 1'b0;
                        rsp_q <= '0;
                        if (req_s) begin
                            op_c   <= pins.ui_in[6:5];
                            addr_c <= pins.ui_in[3:0];
                            data_c <= pins.uio_in;
                            state  <= EXEC;
                        end
                    end
                    EXEC: begin
                        state   <= ACK;
                        ack_q   <= 1'b1;
                        txn_cnt <= txn_cnt + 8'd1;
                        case (op_c)
                            2'b00: begin
                                err_q <= addr_bad;
                                oe_q  <= !addr_bad;
                                rsp_q <= addr_bad ? 8'h00 : cur;
                            end
                            2'b01: begin
                                err_q <= addr_bad;
                                oe_q  <= 1'b0;
                                rsp_q <= '0;
                                if (!addr_bad) regs[idx] <= data_c;
                            end
                            2'b10: begin
                                err_q <= addr_bad;
                                oe_q  <= !addr_bad;
                                rsp_q <= addr_bad ? 8'h00 : sum;
                                if (!addr_bad) regs[idx] <= sum;
                            end
                            default: begin
                                // STATUS reports transactions completed before this one.
                                err_q <= 1'b0;
                                oe_q  <= 1'b1;
                                rsp_q <= txn_cnt;
                            end
                        endcase
                    end
                    ACK: begin
                        if (!req_s) begin
                            state <= IDLE;
                            ack_q <= 1'b0;
                            err_q <= 1'b0;
                            oe_q  <= 1'b0;
                            rsp_q <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign pins.uo_out    = {ack_q, err_q, txn_cnt[5:0]};
    assign pins.uio_out   = rsp_q;
    assign pins.uio_oe    = {8{oe_q}};
    assign pins.dbg_state = state;
endmodule

// File: tb/tb_tt_pin_cmd_responder.sv
// Directed bench for tt_pin_cmd_responder: drivers push expected acks into a
// queue, a monitor pops and compares on every ack rise.
module tb_tt_pin_cmd_responder;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [7:0] n_txn;
    logic [23:0] exp_q[$];

    tt_pin_cmd_responder_if pins ();

    tt_pin_cmd_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic err, input logic [7:0] rsp, input logic oe);
        logic [5:0] c6;
        n_txn = n_txn + 8'd1;
        c6    = n_txn[5:0];
        exp_q.push_back({1'b1, err, c6, rsp, {8{oe}}});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                       input logic exp_err, input logic [7:0] exp_rsp, input logic exp_oe);
        int cyc;
        push_exp(exp_err, exp_rsp, exp_oe);
        pins.ui_in  = {1'b1, op, 1'b0, addr};
        pins.uio_in = data;
        cyc = 0;
        do begin tick(); cyc++; end while (!pins.uo_out[7] && cyc < 20);
        check("ack_rise_latency", cyc, 4);
        pins.ui_in[7] = 1'b0;
        cyc = 0;
        do begin tick(); cyc++; end while (pins.uo_out[7] && cyc < 20);
        check("ack_fall_latency", cyc, 3);
        tick();
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        prev;
        logic [23:0] got;
        logic [23:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pins.uo_out[7] && !prev) begin
                got = {pins.uo_out, pins.uio_out, pins.uio_oe};
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", got, 32'hDEAD_BEEF);
                end else begin
                    exp = exp_q.pop_front();
                    check("ack_response", got, exp);
                end
            end
            prev = pins.uo_out[7];
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        int          ack_cycles;
        logic [7:0]  exp_reg [8];
        n_chk       = 0;
        n_fail      = 0;
        n_txn       = 8'd0;
        rst_n       = 1'b0;
        pins.ena    = 1'b1;
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;

        // reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_uo_out", pins.uo_out, 8'h00);
        check("reset_uio_out", pins.uio_out, 8'h00);
        check("reset_uio_oe", pins.uio_oe, 8'h00);
        check("reset_state", pins.dbg_state, 2'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_uo_out", pins.uo_out, 8'h00);

        // write 0x5A to addr 2, read it back
        txn(2'b01, 4'd2, 8'h5A, 1'b0, 8'h00, 1'b0);
        txn(2'b00, 4'd2, 8'h00, 1'b0, 8'h5A, 1'b1);
        check("txn_cnt_after_two", pins.uo_out, 8'h02);

        // remaining registers still hold reset value
        for (int a = 0; a < 8; a++)
            if (a != 2) txn(2'b00, 4'(a), 8'h00, 1'b0, 8'h00, 1'b1);

        // add with wrap
        txn(2'b01, 4'd3, 8'hF0, 1'b0, 8'h00, 1'b0);
        txn(2'b10, 4'd3, 8'h20, 1'b0, 8'h10, 1'b1);
        txn(2'b00, 4'd3, 8'h00, 1'b0, 8'h10, 1'b1);

        // bad address: write and read rejected, registers untouched
        txn(2'b01, 4'd9, 8'h77, 1'b1, 8'h00, 1'b0);
        txn(2'b00, 4'd12, 8'h00, 1'b1, 8'h00, 1'b0);
        txn(2'b10, 4'd15, 8'h01, 1'b1, 8'h00, 1'b0);
        exp_reg = '{8'h00, 8'h00, 8'h5A, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int a = 0; a < 8; a++)
            txn(2'b00, 4'(a), 8'h00, 1'b0, exp_reg[a], 1'b1);

        // one-cycle req pulse: single one-cycle ack, no retrigger
        push_exp(1'b0, n_txn, 1'b1);
        pins.ui_in = 8'hE0;
        tick();
        pins.ui_in[7] = 1'b0;
        ack_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pins.uo_out[7]) ack_cycles++;
        end
        check("pulse_ack_cycles", ack_cycles, 1);

        // ena dropped during ACK
        push_exp(1'b0, 8'h5A, 1'b1);
        pins.ui_in = 8'h82;
        cyc = 0;
        do begin tick(); cyc++; end while (!pins.uo_out[7] && cyc < 20);
        check("ena_drop_ack_seen", pins.uo_out[7], 1'b1);
        pins.ena = 1'b0;
        tick();
        check("ena_drop_ack_low", pins.uo_out[7], 1'b0);
        check("ena_drop_oe_low", pins.uio_oe, 8'h00);
        check("ena_drop_state", pins.dbg_state, 2'd0);
        pins.ui_in[7] = 1'b0;
        repeat (4) tick();
        pins.ena = 1'b1;
        repeat (2) tick();
        check("ena_return_idle", pins.uo_out, {2'b00, n_txn[5:0]});
        txn(2'b00, 4'd2, 8'h00, 1'b0, 8'h5A, 1'b1);

        // counter wrap through STATUS
        while (n_txn != 8'd255) txn(2'b11, 4'd0, 8'h00, 1'b0, n_txn, 1'b1);
        txn(2'b11, 4'd5, 8'h00, 1'b0, 8'hFF, 1'b1);
        txn(2'b11, 4'd13, 8'h00, 1'b0, 8'h00, 1'b1);

        // reset asserted during EXEC aborts the write
        pins.ui_in  = 8'hA1;
        pins.uio_in = 8'h33;
        repeat (3) tick();
        check("abort_in_exec", pins.dbg_state, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_uo_out", pins.uo_out, 8'h00);
        check("abort_uio_out", pins.uio_out, 8'h00);
        check("abort_uio_oe", pins.uio_oe, 8'h00);
        pins.ui_in = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        n_txn = 8'd0;
        repeat (2) tick();
        for (int a = 0; a < 8; a++)
            txn(2'b00, 4'(a), 8'h00, 1'b0, 8'h00, 1'b1);

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tt_pin_cmd_responder.md
Name: tt_pin_cmd_responder

Overview:
- Design-side responder for the pin-level command handshake that the cocotb bench drives through the top-level pins (ui_in, uio_in, uo_out, uio_out, uio_oe).
- Host raises a request with an opcode and address; the block executes against a small register file and returns an acknowledge, status and optional read data.
- Instantiated inside the tt_um top as the first real function behind the template pinout.

Parameters:
- ADDR_W, 3, register-file address width; NREGS = 2**ADDR_W registers of 8 bits.
- SYNC_STAGES, 2, flops in the req synchronizer; minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  design enable; high when the design is selected.
- ui_in  in  8  [7]=req, [6:5]=opcode, [4]=unused, [3:0]=address.
- uio_in  in  8  write/increment data operand.
- uo_out  out  8  [7]=ack, [6]=err, [5:0]=txn_cnt[5:0].
- uio_out  out  8  read response data.
- uio_oe  out  8  0xFF while driving a read response, otherwise 0x00.

Behaviour:
- Reset: state IDLE; all registers 0x00; txn_cnt 0; uo_out=0x00, uio_out=0x00, uio_oe=0x00; synchronizer flops cleared.
- req passes through SYNC_STAGES flops (req_s). ui_in[6:0] and uio_in are sampled unsynchronized at capture. The host holds them stable from req rise until ack is seen.
- Opcodes:
  - 00 READ: rsp = reg[addr].
  - 01 WRITE: reg[addr] = uio_in; no response drive.
  - 10 ADD: reg[addr] = (reg[addr] + uio_in) mod 256; rsp = new value.
  - 11 STATUS: rsp = txn_cnt[7:0]; address ignored; never errs.
- err is set when addr >= NREGS (ui_in[3:0] above NREGS-1) for ops 00/01/10. On err: no register change, rsp = 0x00.
- FSM IDLE -> EXEC -> ACK -> IDLE:
  - IDLE: ack=0, uio_oe=0x00. If ena && req_s==1, capture opcode/addr/data, go to EXEC.
  - EXEC (1 cycle): perform the op; register the rsp and err values; go to ACK.
  - ACK: ack=1; err valid; txn_cnt += 1 (mod 256) on entry, one increment per transaction including errors. uio_out=rsp and uio_oe=0xFF for READ/ADD/STATUS without err; otherwise uio_oe=0x00. Stay while req_s==1; leave when req_s==0.
  - On leaving ACK: ack, err, uio_oe return to 0 on the same edge, and uio_out goes to 0x00.
- Latency: with req high before edge 1, ack is high after edge SYNC_STAGES+2 (edge 4 at default). ack falls SYNC_STAGES+1 edges after req falls.
- No new capture occurs until ack has dropped and req_s is seen low, then high again. A held-high req never re-triggers.
- req dropping during EXEC (protocol violation): ACK is still entered; ack is high for exactly 1 cycle; the op still completes.
- ena low: FSM forced to IDLE next edge; ack, err, uio_oe cleared; registers and txn_cnt retained; req ignored. If req is still high when ena returns, a new transaction starts.
- Asynchronous reset mid-transaction aborts the transaction and restores the reset values. If req is held high through reset release, a new transaction starts after the sync delay.
- All outputs are registered; no combinational path from pins to outputs.

Test Plan:
- Reset then idle: rst_n low 3 cycles, ena=1, req=0 -> uo_out=0x00, uio_oe=0x00, all READs return 0x00.
- WRITE then READ: write 0x5A to addr 2 (ui_in=0xA2, uio_in=0x5A), then READ addr 2 (ui_in=0x82).
  - ack rises on edge 4 after req.
  - READ gives uio_out=0x5A, uio_oe=0xFF, err=0.
  - uo_out[5:0] = 2 after both transactions.
- ADD wrap: reg3=0xF0, ADD uio_in=0x20 -> uio_out=0x10; a following READ of addr 3 returns 0x10.
- Bad address: WRITE 0x77 to addr 9 -> ack with err=1 and uio_oe=0x00; all 8 registers unchanged; txn_cnt still increments.
- STATUS and counter wrap: after 255 transactions, STATUS returns 0xFF; the next STATUS returns 0x00.
- Violations and aborts:
  - req pulsed 1 cycle -> ack pulses exactly 1 cycle, no second transaction.
  - ena dropped during ACK -> ack=0 next edge.
  - rst_n asserted during EXEC -> outputs 0x00 immediately, registers 0x00.
